// File: rtl/data_mem_responder.sv
// Data-memory target for the core's load/store path: one request at a time over valid/ready,
// programmable wait states, word-addressed byte-writable RAM, single held response.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                req_write,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_write;
    logic              lat_err;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic [IDX_W-1:0]  lat_idx;
    logic              req_err;
    logic              access;
    logic              commit;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    assign req_ready = (state == S_IDLE) && !rst;
    assign req_err   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

    // The first cycle in RESP (response not yet raised) is the single RAM access slot.
    assign access = (state == S_RESP) && !rsp_valid && !rst;
    assign commit = access && lat_write && !lat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        // NOTE: the captured request fields are plain datapath registers; they are
                        // only consumed after an accept, so they need no reset value.
                        lat_write <= req_write;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        lat_idx   <= req_addr[IDX_W+1:2];
                        lat_err   <= req_err;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_err;
                        rsp_rdata <= (lat_err || lat_write) ? '0 : mem[lat_idx];
                    end else if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: RAM has no reset branch so it maps onto block memory; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (lat_be[b]) begin
                    mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
